// File: rtl/record_step_generator.sv
// rtl/record_step_generator.sv - pops 4-byte motion records from the FIFO and emits step/dir pulse trains
// Optional: define STEPGEN_RECORD_COUNT_EN to add the records_done counter output.
module record_step_generator #(
    parameter int WORD_SIZE    = 8,
    parameter int RECORD_WORDS = 4,
    parameter int FIFO_SIZE_W  = 5,
    parameter int AXES         = 4,
    parameter int PRESCALE     = 16,
    parameter int PULSE_WIDTH  = 16,
    parameter int DIR_SETUP    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [FIFO_SIZE_W-1:0] fifo_size,
    input  logic                   fifo_empty,
    output logic                   fifo_read_en,
    input  logic [WORD_SIZE-1:0]   fifo_data,
    output logic [AXES-1:0]        step,
    output logic [AXES-1:0]        dir,
    output logic                   busy
`ifdef STEPGEN_RECORD_COUNT_EN
    ,
    output logic [7:0]             records_done
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_SETUP = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [15:0] PRESCALE_W = 16'(PRESCALE);
    localparam logic [15:0] MIN_PERIOD = 16'(2 * PULSE_WIDTH);
    localparam logic [15:0] PULSE_W    = 16'(PULSE_WIDTH);
    localparam logic [15:0] SETUP_LAST = 16'(DIR_SETUP - 1);
    localparam logic [2:0]  FETCH_LAST = 3'(RECORD_WORDS);

    logic [2:0]      state;
    logic [2:0]      fcnt;
    logic [15:0]     scnt;
    logic [15:0]     pcnt;
    logic [15:0]     period;
    logic [15:0]     rc;
    logic [AXES-1:0] mask;
    logic [AXES-1:0] dir_nxt;
    logic            paused;
    logic            start_ok;
    logic [15:0]     ticks;
    logic [15:0]     prod;
    logic [15:0]     period_calc;

    // A record is only started when all of its words are already buffered.
    assign start_ok = enable && (fifo_size >= FIFO_SIZE_W'(RECORD_WORDS)) && !fifo_empty;

    always_comb begin
        ticks = 16'(fifo_data);
        if (ticks == 16'd0) begin
            ticks = 16'd1;
        end
        prod        = ticks * PRESCALE_W;
        period_calc = (prod < MIN_PERIOD) ? MIN_PERIOD : prod;
    end

    assign fifo_read_en = (state == S_FETCH) && (fcnt < FETCH_LAST);
    assign step         = (state == S_RUN && !paused && pcnt < PULSE_W) ? mask : '0;
    assign busy         = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            fcnt    <= '0;
            scnt    <= '0;
            pcnt    <= '0;
            period  <= '0;
            rc      <= '0;
            mask    <= '0;
            dir     <= '0;
            dir_nxt <= '0;
            paused  <= 1'b0;
`ifdef STEPGEN_RECORD_COUNT_EN
            records_done <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        state <= S_FETCH;
                        fcnt  <= '0;
                    end
                end
                S_FETCH: begin
                    // Read data lags the pop by one cycle, so byte k lands while fcnt == k+1.
                    fcnt <= fcnt + 3'd1;
                    case (fcnt)
                        3'd1: begin
                            mask    <= fifo_data[AXES-1:0];
                            dir_nxt <= fifo_data[4 +: AXES];
                        end
                        3'd2: rc[7:0]  <= fifo_data;
                        3'd3: rc[15:8] <= fifo_data;
                        3'd4: begin
                            period <= period_calc;
                            dir    <= dir_nxt;
                            scnt   <= '0;
                            state  <= S_SETUP;
                        end
                        default: ;
                    endcase
                end
                S_SETUP: begin
                    if (scnt == SETUP_LAST) begin
                        pcnt   <= '0;
                        paused <= 1'b0;
                        state  <= (rc == 16'd0) ? S_DONE : S_RUN;
                    end else begin
                        scnt <= scnt + 16'd1;
                    end
                end
                S_RUN: begin
                    if (paused) begin
                        if (enable) begin
                            paused <= 1'b0;
                        end
                    end else begin
                        if (pcnt == 16'd0) begin
                            rc <= rc - 16'd1;
                        end
                        // enable is only honoured at the period boundary so pulses never get cut.
                        if (pcnt == period - 16'd1) begin
                            pcnt <= '0;
                            if (rc == 16'd0) begin
                                state <= S_DONE;
                            end else if (!enable) begin
                                paused <= 1'b1;
                            end
                        end else begin
                            pcnt <= pcnt + 16'd1;
                        end
                    end
                end
                S_DONE: begin
`ifdef STEPGEN_RECORD_COUNT_EN
                    records_done <= records_done + 8'd1;
`endif
                    if (start_ok) begin
                        state <= S_FETCH;
                        fcnt  <= '0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_record_step_generator.sv
// tb/tb_record_step_generator.sv - directed bench for record_step_generator with a simple FIFO model
module tb_record_step_generator;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [4:0] fifo_size;
    logic       fifo_empty;
    logic       fifo_read_en;
    logic [7:0] fifo_data;
    logic [3:0] step;
    logic [3:0] dir;
    logic       busy;
`ifdef STEPGEN_RECORD_COUNT_EN
    logic [7:0] records_done;
    int         rd_base;
`endif

    logic [7:0] mem [0:63];
    int         wr_ptr;
    int         rd_ptr;

    int checks;
    int failures;

    int         cyc;
    int         pop_first;
    int         pop_cnt;
    int         rise_n;
    int         rise_at [0:7];
    logic [3:0] rise_val [0:7];
    int         hi_cnt [0:3];
    int         dir_n;
    int         dir_at [0:3];
    logic [3:0] dir_v [0:3];
    int         busy_fall;
    logic [3:0] prev_step;
    logic [3:0] prev_dir;
    logic       prev_busy;
    bit         seen;

    record_step_generator dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .fifo_size    (fifo_size),
        .fifo_empty   (fifo_empty),
        .fifo_read_en (fifo_read_en),
        .fifo_data    (fifo_data),
        .step         (step),
        .dir          (dir),
        .busy         (busy)
`ifdef STEPGEN_RECORD_COUNT_EN
        ,
        .records_done (records_done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_size  = 5'(wr_ptr - rd_ptr);
    assign fifo_empty = (wr_ptr == rd_ptr);

    initial rd_ptr = 0;
    always @(posedge clk) begin
        if (fifo_read_en) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr      = wr_ptr + 1;
    endtask

    task automatic mon_reset();
        cyc       = 0;
        pop_first = -1;
        pop_cnt   = 0;
        rise_n    = 0;
        dir_n     = 0;
        busy_fall = -1;
        for (int b = 0; b < 4; b++) hi_cnt[b] = 0;
        prev_step = step;
        prev_dir  = dir;
        prev_busy = busy;
    endtask

    // Sample on the falling edge; cycle index counts samples since mon_reset.
    task automatic observe(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            if (fifo_read_en) begin
                if (pop_cnt == 0) pop_first = cyc;
                pop_cnt++;
            end
            if (step != 4'd0 && prev_step == 4'd0 && rise_n < 8) begin
                rise_at[rise_n]  = cyc;
                rise_val[rise_n] = step;
                rise_n++;
            end
            for (int b = 0; b < 4; b++) if (step[b]) hi_cnt[b]++;
            if (dir != prev_dir && dir_n < 4) begin
                dir_at[dir_n] = cyc;
                dir_v[dir_n]  = dir;
                dir_n++;
            end
            if (prev_busy && !busy && busy_fall < 0) busy_fall = cyc;
            prev_step = step;
            prev_dir  = dir;
            prev_busy = busy;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        wr_ptr   = 0;
        rst      = 1'b1;
        enable   = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_step", 32'(step), 0);
        check("reset_dir", 32'(dir), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_read_en", 32'(fifo_read_en), 0);
`ifdef STEPGEN_RECORD_COUNT_EN
        check("reset_records_done", 32'(records_done), 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Three words buffered must never start a fetch; the fourth word does.
        push(8'h15); push(8'h03); push(8'h00);
        mon_reset();
        observe(10);
        check("partial_no_pop", 32'(pop_cnt), 0);
        push(8'h04);
        mon_reset();
        observe(215);
        check("a_pop_first", 32'(pop_first), 1);
        check("a_pop_cnt", 32'(pop_cnt), 4);
        check("a_dir_at", 32'(dir_at[0]), 6);
        check("a_dir_val", 32'(dir_v[0]), 1);
        check("a_rise_n", 32'(rise_n), 3);
        check("a_rise0", 32'(rise_at[0]), 14);
        check("a_rise1", 32'(rise_at[1]), 78);
        check("a_rise2", 32'(rise_at[2]), 142);
        check("a_step_val", 32'(rise_val[0]), 5);
        check("a_hi0", 32'(hi_cnt[0]), 48);
        check("a_odd_quiet", 32'(hi_cnt[1] + hi_cnt[3]), 0);
        check("a_busy_fall", 32'(busy_fall), 207);

        // Direction-only record.
        push(8'hF0); push(8'h00); push(8'h00); push(8'h00);
        mon_reset();
        observe(25);
        check("b_pop_first", 32'(pop_first), 1);
        check("b_dir_at", 32'(dir_at[0]), 6);
        check("b_dir_val", 32'(dir_v[0]), 15);
        check("b_rise_n", 32'(rise_n), 0);
        check("b_busy_fall", 32'(busy_fall), 15);

        // One tick at PRESCALE 16 is shorter than two pulse widths: clamped to 32.
        push(8'h01); push(8'h02); push(8'h00); push(8'h01);
        mon_reset();
        observe(90);
        check("c_dir_val", 32'(dir_v[0]), 0);
        check("c_rise_n", 32'(rise_n), 2);
        check("c_rise0", 32'(rise_at[0]), 14);
        check("c_rise1", 32'(rise_at[1]), 46);
        check("c_hi0", 32'(hi_cnt[0]), 32);
        check("c_busy_fall", 32'(busy_fall), 79);

        // Two queued records with a pause in the middle of the first.
`ifdef STEPGEN_RECORD_COUNT_EN
        rd_base = int'(records_done);
`endif
        push(8'h12); push(8'h02); push(8'h00); push(8'h04);
        push(8'h08); push(8'h01); push(8'h00); push(8'h02);
        mon_reset();
        observe(20);
        enable = 1'b0;
        observe(80);
        enable = 1'b1;
        observe(120);
        check("d_pop_cnt", 32'(pop_cnt), 8);
        check("d_rise_n", 32'(rise_n), 3);
        check("d_rise0", 32'(rise_at[0]), 14);
        check("d_resume", 32'(rise_at[1]), 101);
        check("d_step_val1", 32'(rise_val[1]), 2);
        check("d_hi1", 32'(hi_cnt[1]), 32);
        check("d_dir2_at", 32'(dir_at[1]), 171);
        check("d_rise2", 32'(rise_at[2]), 179);
        check("d_step_val2", 32'(rise_val[2]), 8);
        check("d_busy_fall", 32'(busy_fall), 212);
`ifdef STEPGEN_RECORD_COUNT_EN
        check("d_records_done", 32'(int'(records_done) - rd_base), 2);
`endif

        // Asynchronous reset while a step pulse is high.
        push(8'h13); push(8'h05); push(8'h00); push(8'h04);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (step != 4'd0) seen = 1'b1;
        end
        check("e_step_reached", 32'(seen), 1);
        check("e_dir_before", 32'(dir), 1);
        rst = 1'b1;
        #1;
        check("e_async_step", 32'(step), 0);
        check("e_async_dir", 32'(dir), 0);
        check("e_async_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("e_idle_busy", 32'(busy), 0);
        check("e_idle_step", 32'(step), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/record_step_generator.md
Name: record_step_generator

Overview:
- Downstream consumer of the SPI-fed record FIFO.
- Waits until a complete record is buffered, pops its RECORD_WORDS bytes and decodes axis mask, direction, step count and step period.
- Emits step/direction pulse trains on the board's step outputs (p1..p8).
- Turns buffered motion records into real-time step timing, decoupled from SPI traffic.

Parameters:
- WORD_SIZE, 8: FIFO word width; the record layout requires 8.
- RECORD_WORDS, 4: words per record; the layout requires 4.
- FIFO_SIZE_W, 5: width of the FIFO occupancy input, in words.
- AXES, 4: number of step/dir output pairs.
- PRESCALE, 16: clocks per period tick.
- PULSE_WIDTH, 16: step high time in clocks.
- DIR_SETUP, 8: clocks between a direction update and the first step edge.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- enable  in  1  run permission; low pauses the block at the next period boundary.
- fifo_size  in  FIFO_SIZE_W  FIFO occupancy in words.
- fifo_empty  in  1  FIFO empty flag.
- fifo_read_en  out  1  pop strobe; one word per high cycle.
- fifo_data  in  WORD_SIZE  FIFO read data; registered, valid the cycle after fifo_read_en.
- step  out  AXES  step pulses.
- dir  out  AXES  direction levels.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset: step=0, dir=0, fifo_read_en=0, busy=0; state=IDLE; all counters cleared.
- Reset mid-fetch: words already popped are lost; the FIFO is not rewound. This is accepted; the host must re-sync via the SPI no-op protocol.
- Record layout (byte order as popped):
  - b0 = {dir[3:0], mask[3:0]}
  - b1 = count[7:0]
  - b2 = count[15:8]
  - b3 = period ticks; 0 is treated as 1.
  - For AXES<4, upper nibble bits above AXES are ignored.
- Period: period_clk = max(b3*PRESCALE, 2*PULSE_WIDTH), computed in 16-bit unsigned.
- IDLE: go to FETCH when enable=1, fifo_size >= RECORD_WORDS and fifo_empty=0. Never pops a partial record.
- FETCH: fifo_read_en high for exactly 4 consecutive cycles (F0..F3). Bytes are captured on F1..F4. The block enters SETUP the cycle after F4.
- SETUP:
  - dir <= b0[7:4] on entry.
  - Held DIR_SETUP clocks.
  - If count==0, go straight to DONE after the hold (direction-only record).
- RUN:
  - Period counter runs 0..period_clk-1.
  - step = mask while counter < PULSE_WIDTH, else 0.
  - Step count decrements at counter==0.
  - After the last step's full period, go to DONE.
  - First step rising edge is exactly DIR_SETUP clocks after the dir update.
- DONE (1 cycle):
  - Go to FETCH if enable=1 and a full record is buffered, else IDLE.
  - Back-to-back records keep the last period intact; no extra gap beyond FETCH(5)+DONE(1)+DIR_SETUP.
- Pause: enable low in RUN is sampled only at counter==period_clk-1. The block holds with step=0 and the counter frozen at 0, and resumes with the next step at counter==0.
- enable low in IDLE or DONE: no new fetch starts. A FETCH in progress always completes.
- dir never changes while any step bit is high.
- mask==0 with count>0: times out all periods with no pulses.
- fifo_empty rising during FETCH is a FIFO underflow. The block still completes 4 pops; the captured data is don't-care.

Optional Feature:
- Macro: STEPGEN_RECORD_COUNT_EN.
- Defined: adds output records_done [7:0]. It is reset to 0, increments in DONE and wraps 255->0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset while RUN with step high -> step=0, dir=0, busy=0 in the same cycle (async); IDLE after release.
- fifo_size=3 held -> no fifo_read_en ever. Raise to 4 -> fifo_read_en high exactly 4 cycles, starting one cycle later.
- Record {0x15,0x03,0x00,0x04} ->
  - dir=0001.
  - 8 clocks later, step[0] and step[2] pulse 16 clocks high, 3 pulses, 64-clock spacing.
  - step[1] and step[3] stay 0.
  - busy falls 1 cycle after the third period.
- Record {0xF0,0x00,0x00,0x00} -> dir=1111, no steps, DONE after 8 clocks.
- Record {0x01,0x02,0x00,0x01} -> period clamped to 32 clocks (not 16); 2 pulses 32 apart.
- Two records queued (8 words), enable dropped mid first record ->
  - Current period finishes, step held 0.
  - Re-enable: remaining steps resume.
  - Second record fetched.
  - With STEPGEN_RECORD_COUNT_EN, records_done=2.
